serial_to_parallel_buffer: RTL and testbench

//  Receive-side counterpart of the UART transmit buffer. Collects NUM_BYTES bytes from the UART

---
 rtl/serial_buffer_pkg.sv | 10 +
 rtl/serial_to_parallel_buffer_if.sv | 25 ++
 rtl/serial_to_parallel_buffer_interbyte_timer.sv | 26 ++
 rtl/serial_to_parallel_buffer.sv | 99 +++++++++
 tb/tb_serial_to_parallel_buffer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_buffer_pkg.sv
// serial_buffer_pkg: shared state encoding and default sizing for the serial transmit/receive buffers
package serial_buffer_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;
    localparam int DEFAULT_NUM_BYTES      = 10;
    localparam int DEFAULT_TIMEOUT_CYCLES = 100000;
endpackage

// File: rtl/serial_to_parallel_buffer_if.sv
// serial_to_parallel_buffer_if: byte-strobe input side and frame handshake output side of the receive buffer
interface serial_to_parallel_buffer_if
    import serial_buffer_pkg::*;
#(
    parameter int NUM_BYTES = DEFAULT_NUM_BYTES
);
    logic [7:0]             rx_byte;
    logic                   rx_valid;
    logic                   out_ready;
    logic [NUM_BYTES*8-1:0] data_out;
    logic                   data_valid;
    logic                   active;
    logic                   overrun;
    logic                   timeout_err;

    modport master (
        output rx_byte, rx_valid, out_ready,
        input  data_out, data_valid, active, overrun, timeout_err
    );

    modport slave (
        input  rx_byte, rx_valid, out_ready,
        output data_out, data_valid, active, overrun, timeout_err
    );
endinterface

// File: rtl/serial_to_parallel_buffer_interbyte_timer.sv
// interbyte_timer: counts idle cycles while run is high; expired flags the TIMEOUT_CYCLES-th idle cycle
module interbyte_timer
    import serial_buffer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    // a clear on the expiry cycle suppresses expiry so the arriving byte wins
    assign expired = run && !clear && (cnt == W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (!run || clear || expired) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/serial_to_parallel_buffer.sv
// serial_to_parallel_buffer: assembles NUM_BYTES strobed bytes into one word with a valid/ready handshake.
// Define SP_TIMEOUT_EN to discard partial frames after TIMEOUT_CYCLES idle cycles.
module serial_to_parallel_buffer
    import serial_buffer_pkg::*;
#(
    parameter int NUM_BYTES      = DEFAULT_NUM_BYTES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic                        clk,
    input logic                        rst_n,
    serial_to_parallel_buffer_if.slave bus
);
    localparam int CNT_W  = $clog2(NUM_BYTES + 1);
    localparam int BASE_W = $clog2(NUM_BYTES * 8);

    if (NUM_BYTES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("serial_to_parallel_buffer: NUM_BYTES must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic [NUM_BYTES*8-1:0] data_out;
    logic                   data_valid;
    logic                   active;
    logic                   overrun;
    logic                   timeout_err;
    logic                   expired;
    logic                   accept;
    logic                   full;
    logic [CNT_W-1:0]       slot;
    logic [BASE_W-1:0]      base;

`ifdef SP_TIMEOUT_EN
    interbyte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state == FILL),
        .clear  (bus.rx_valid),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    // a byte landing in HOLD alongside the transfer restarts the frame at slot 0
    always_comb begin
        accept = bus.rx_valid && (state == IDLE || state == FILL || (state == HOLD && bus.out_ready));
        slot   = (state == FILL) ? count : '0;
        base   = BASE_W'({slot, 3'b000});
        full   = (slot == CNT_W'(NUM_BYTES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            active      <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            if (accept) begin
                data_out[base +: 8] <= bus.rx_byte;
                count               <= slot + 1'b1;
                state               <= full ? HOLD : FILL;
                data_valid          <= full;
                active              <= 1'b1;
            end else if (state == HOLD && bus.out_ready) begin
                count      <= '0;
                state      <= IDLE;
                data_valid <= 1'b0;
                active     <= 1'b0;
            end else if (state == HOLD) begin
                overrun <= bus.rx_valid;
            end else if (state == FILL && expired) begin
                count       <= '0;
                state       <= IDLE;
                active      <= 1'b0;
                timeout_err <= 1'b1;
            end else if (state != IDLE && state != FILL) begin
                count      <= '0;
                state      <= IDLE;
                data_valid <= 1'b0;
                active     <= 1'b0;
            end
        end
    end

    assign bus.data_out    = data_out;
    assign bus.data_valid  = data_valid;
    assign bus.active      = active;
    assign bus.overrun     = overrun;
    assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_serial_to_parallel_buffer.sv
// tb_serial_to_parallel_buffer: vector table plus hand sequences; completed frames checked through a scoreboard queue
module tb_serial_to_parallel_buffer;
    import serial_buffer_pkg::*;

    localparam int NB = DEFAULT_NUM_BYTES;
    localparam int W  = NB * 8;
`ifdef SP_TIMEOUT_EN
    localparam int TO = 20;
`else
    localparam int TO = DEFAULT_TIMEOUT_CYCLES;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_to_parallel_buffer_if #(.NUM_BYTES(NB)) bus ();

    serial_to_parallel_buffer #(
        .NUM_BYTES     (NB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic       v;
        logic [7:0] b;
        logic       rdy;
        logic       push;
        logic [7:0] pb;
        logic       dv;
        logic       act;
        logic       ov;
    } vec_t;

    vec_t           tbl[24];
    logic [W-1:0]   expq[$];
    logic [W-1:0]   hold;
    int             checks = 0;
    int             errors = 0;
    int             to_seen = 0;
    int             unstable;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mkframe(input logic [7:0] b0);
        logic [W-1:0] f;
        for (int i = 0; i < NB; i++) f[i*8 +: 8] = b0 + 8'(i);
        return f;
    endfunction

    function automatic vec_t mkv(input logic v, input logic [7:0] b, input logic rdy, input logic push,
                                 input logic [7:0] pb, input logic dv, input logic act, input logic ov);
        vec_t r;
        r.v = v; r.b = b; r.rdy = rdy; r.push = push; r.pb = pb; r.dv = dv; r.act = act; r.ov = ov;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        step();
        bus.rx_valid = 1'b0;
    endtask

    // out_ready is already settled for the coming edge here, so dv & ready marks a transfer
    always @(negedge clk) begin
        if (bus.timeout_err === 1'b1) to_seen++;
        if (rst_n && bus.data_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame: unexpected transfer of %0h, expected none", bus.data_out);
            end else begin
                chk("frame", bus.data_out, expq.pop_front());
            end
        end
    end

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.out_ready = 1'b0;

        for (int i = 0; i < 10; i++)
            tbl[i] = mkv(1'b1, 8'h50 + 8'(i), 1'b0, i == 9, 8'h50, i == 9, 1'b1, 1'b0);
        tbl[10] = mkv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        tbl[11] = mkv(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        tbl[12] = mkv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        tbl[13] = mkv(1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++)
            tbl[14+i] = mkv(1'b1, 8'h42 + 8'(i), 1'b0, i == 8, 8'h41, i == 8, 1'b1, 1'b0);
        tbl[23] = mkv(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", bus.data_out, '0);
        chk("rst_dv", W'(bus.data_valid), '0);
        chk("rst_active", W'(bus.active), '0);
        chk("rst_overrun", W'(bus.overrun), '0);
        chk("rst_timeout", W'(bus.timeout_err), '0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 24; i++) begin
            bus.rx_valid  = tbl[i].v;
            bus.rx_byte   = tbl[i].b;
            bus.out_ready = tbl[i].rdy;
            if (tbl[i].push) expq.push_back(mkframe(tbl[i].pb));
            step();
            chk($sformatf("vec%0d_dv", i), W'(bus.data_valid), W'(tbl[i].dv));
            chk($sformatf("vec%0d_active", i), W'(bus.active), W'(tbl[i].act));
            chk($sformatf("vec%0d_overrun", i), W'(bus.overrun), W'(tbl[i].ov));
        end
        bus.rx_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();

        bus.out_ready = 1'b1;
        for (int i = 0; i < NB; i++) begin
            if (i == NB - 1) expq.push_back(mkframe(8'h30));
            send(8'h30 + 8'(i));
        end
        chk("ascii_dv", W'(bus.data_valid), W'(1'b1));
        chk("ascii_lo", W'(bus.data_out[7:0]), W'(8'h30));
        chk("ascii_hi", W'(bus.data_out[W-1 -: 8]), W'(8'h39));
        step();
        chk("ascii_dv_pulse", W'(bus.data_valid), '0);
        chk("ascii_idle", W'(bus.active), '0);

        bus.out_ready = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i == NB - 1) expq.push_back(mkframe(8'h20));
            send(8'h20 + 8'(i));
        end
        hold = bus.data_out;
        unstable = 0;
        repeat (50) begin
            step();
            if (bus.data_valid !== 1'b1 || bus.data_out !== hold) unstable++;
        end
        chk("hold_stable", W'(unstable), '0);
        bus.out_ready = 1'b1;
        step();
        chk("hold_xfer_dv", W'(bus.data_valid), '0);
        chk("hold_xfer_idle", W'(bus.active), '0);
        bus.out_ready = 1'b0;

        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
        chk("partial_active", W'(bus.active), W'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_data", bus.data_out, '0);
        chk("async_dv", W'(bus.data_valid), '0);
        chk("async_active", W'(bus.active), '0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NB; i++) begin
            if (i == NB - 1) expq.push_back(mkframe(8'h60));
            send(8'h60 + 8'(i));
        end
        chk("post_rst_dv", W'(bus.data_valid), W'(1'b1));
        bus.out_ready = 1'b1;
        step();
        chk("post_rst_idle", W'(bus.active), '0);
        bus.out_ready = 1'b0;

`ifdef SP_TIMEOUT_EN
        for (int i = 0; i < 3; i++) send(8'h01 + 8'(i));
        repeat (TO - 1) step();
        chk("to_before", W'(bus.timeout_err), '0);
        chk("to_before_active", W'(bus.active), W'(1'b1));
        step();
        chk("to_pulse", W'(bus.timeout_err), W'(1'b1));
        chk("to_idle", W'(bus.active), '0);
        step();
        chk("to_pulse_end", W'(bus.timeout_err), '0);
        for (int i = 0; i < NB; i++) begin
            if (i == NB - 1) expq.push_back(mkframe(8'h80));
            send(8'h80 + 8'(i));
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        send(8'h70);
        repeat (TO - 1) step();
        send(8'h71);
        chk("expiry_byte_no_to", W'(bus.timeout_err), '0);
        chk("expiry_byte_active", W'(bus.active), W'(1'b1));
        for (int i = 2; i < NB; i++) begin
            if (i == NB - 1) expq.push_back(mkframe(8'h70));
            send(8'h70 + 8'(i));
        end
        chk("expiry_frame_dv", W'(bus.data_valid), W'(1'b1));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("timeout_count", W'(to_seen), W'(1));
`else
        repeat (30) step();
        chk("partial_waits", W'(bus.active), '0);
        chk("timeout_count", W'(to_seen), '0);
`endif
        step();
        chk("sb_empty", W'(expq.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
